// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the read- and write-side controls of the async FIFO.
//   - FIFO_ADDR_W / PTR_W : default RAM address width and pointer width
//                           (pointers carry one extra wrap bit).
//   - bin2gray / gray2bin : width-generic conversions. They operate on a
//                           32-bit container; callers zero-extend narrower
//                           values. This is exact because leading zeros map
//                           to leading zeros in both directions.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_W       = FIFO_ADDR_W + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side control of the async FIFO, running in the read clock domain.
//   Owns the read pointer and derives the empty / almost_empty flags and the
//   fill level from the write pointer, which arrives already synchronized.
//   Because of that synchronizer, the flags are pessimistic. Newly written data
//   becomes visible late, but empty is never asserted late.
// Ports
//   clk, rst        read clock, asynchronous active-high reset
//   rd_en           read request
//   wptr_gray_sync  write pointer (Gray), synchronized to clk
//   underflow_clr   clears the sticky underflow flag
//   raddr           RAM read address (low bits of the binary read pointer)
//   rptr_gray       registered Gray read pointer for the write-domain synchronizer
//   rd_fire         read accepted this cycle
//   empty           registered empty flag
//   almost_empty    registered, level <= AEMPTY_THRESH
//   rd_level        registered fill level, 0..2**ADDR_W
//   underflow       sticky: a read was attempted while empty
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  input  logic              underflow_clr,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              rd_fire,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] rbin_reg;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_reg;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] level_reg;
  logic [PW-1:0] level_next;
  logic          empty_reg;
  logic          empty_next;
  logic          aempty_reg;
  logic          aempty_next;
  logic          underflow_reg;
  logic          underflow_next;
  logic [31:0]   rgray_wide;
  logic [31:0]   wbin_wide;

  // Reads are gated by the registered empty flag, so the pointer never passes
  // the write pointer. Over-reads are only recorded in the underflow flag.
  assign rd_fire = rd_en & ~empty_reg;

  always_comb begin
    rbin_next      = rbin_reg + {{(PW-1){1'b0}}, rd_fire};
    rgray_wide     = bin2gray(32'(rbin_next));
    rgray_next     = rgray_wide[PW-1:0];
    wbin_wide      = gray2bin(32'(wptr_gray_sync));
    wbin_sync      = wbin_wide[PW-1:0];
    // Modular subtraction over PW bits. The extra wrap bit distinguishes a
    // full FIFO (level 2**ADDR_W) from an empty one.
    level_next     = wbin_sync - rbin_next;
    empty_next     = (rgray_next == wptr_gray_sync);
    aempty_next    = (level_next <= THRESH);
    underflow_next = underflow_reg;
    // A set and a clear in the same cycle resolve in favour of set.
    if (rd_en && empty_reg) begin
      underflow_next = 1'b1;
    end else if (underflow_clr) begin
      underflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin_reg      <= '0;
      rgray_reg     <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      aempty_reg    <= 1'b1;
      underflow_reg <= 1'b0;
    end else begin
      rbin_reg      <= rbin_next;
      rgray_reg     <= rgray_next;
      level_reg     <= level_next;
      empty_reg     <= empty_next;
      aempty_reg    <= aempty_next;
      underflow_reg <= underflow_next;
    end
  end

  assign raddr        = rbin_reg[ADDR_W-1:0];
  assign rptr_gray    = rgray_reg;
  assign empty        = empty_reg;
  assign almost_empty = aempty_reg;
  assign rd_level     = level_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
//   Directed scenarios followed by random traffic. The reference model tracks
//   the total number of reads and visible writes as plain integers and derives
//   every expected output from them.
module tb_fifo_rd_ctrl;

  localparam int ADDR_W = 2;
  localparam int THR    = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic [ADDR_W:0]   wptr_gray_sync;
  logic              underflow_clr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr_gray;
  logic              rd_fire;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;

  fifo_rd_ctrl #(.ADDR_W(ADDR_W), .AEMPTY_THRESH(THR)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_en          (rd_en),
    .wptr_gray_sync (wptr_gray_sync),
    .underflow_clr  (underflow_clr),
    .raddr          (raddr),
    .rptr_gray      (rptr_gray),
    .rd_fire        (rd_fire),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .rd_level       (rd_level),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: totals of accepted reads and of writes made visible.
  int rcnt = 0;
  int wcnt = 0;
  bit m_uf = 0;

  function automatic logic [ADDR_W:0] gray_of(input int n);
    int b;
    b = n % (2 * DEPTH);
    return (ADDR_W+1)'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int lvl;
    lvl = wcnt - rcnt;
    chk({ctx, " empty"},        32'(empty),        32'(lvl == 0));
    chk({ctx, " almost_empty"}, 32'(almost_empty), 32'(lvl <= THR));
    chk({ctx, " rd_level"},     32'(rd_level),     32'(lvl));
    chk({ctx, " raddr"},        32'(raddr),        32'(rcnt % DEPTH));
    chk({ctx, " rptr_gray"},    32'(rptr_gray),    32'(gray_of(rcnt)));
    chk({ctx, " underflow"},    32'(underflow),    32'(m_uf));
  endtask

  // One clock: make wadd more writes visible, optionally request a read.
  task automatic do_step(input string ctx, input bit rd, input int wadd, input bit clr);
    int  lvl;
    bit  fire;
    @(negedge clk);
    wcnt           += wadd;
    rd_en          = rd;
    underflow_clr  = clr;
    wptr_gray_sync = gray_of(wcnt);
    lvl  = wcnt - wadd - rcnt;   // level currently shown by the registered flags
    fire = rd && (lvl != 0);
    #1 chk({ctx, " rd_fire"}, 32'(rd_fire), 32'(fire));
    @(posedge clk);
    #1;
    if (rd && lvl == 0) m_uf = 1'b1;
    else if (clr)       m_uf = 1'b0;
    if (fire) rcnt++;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic rst_pulse(input string ctx);
    @(negedge clk);
    #2;
    rst            = 1'b1;
    rd_en          = 1'b0;
    underflow_clr  = 1'b0;
    wptr_gray_sync = '0;
    rcnt = 0;
    wcnt = 0;
    m_uf = 1'b0;
    #1 check_all(ctx);
    #1 rst = 1'b0;
  endtask

  initial begin
    int lvl;
    int wadd;
    rst            = 1'b1;
    rd_en          = 1'b1;
    wptr_gray_sync = '0;
    underflow_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Read attempted on empty right after reset.
    do_step("t1_rd_empty", 1'b1, 0, 1'b0);

    // Three entries appear, then drain them.
    do_step("t2_fill", 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) do_step("t2_drain", 1'b1, 0, 1'b0);

    // Pointer wrap from bin 7 to 0.
    do_step("t3_fill", 1'b0, 4, 1'b0);
    for (int i = 0; i < 4; i++) do_step("t3_read", 1'b1, 0, 1'b0);
    do_step("t3_wptr_wrap", 1'b0, 1, 1'b0);
    do_step("t3_rptr_wrap", 1'b1, 0, 1'b0);

    // Full FIFO.
    rst_pulse("t4_rst");
    do_step("t4_full", 1'b0, DEPTH, 1'b0);
    do_step("t4_read", 1'b1, 0, 1'b0);

    // Sticky underflow: set wins over clear, then clear alone.
    for (int i = 0; i < 3; i++) do_step("t5_drain", 1'b1, 0, 1'b0);
    do_step("t5_set_uf", 1'b1, 0, 1'b0);
    do_step("t5_set_clr", 1'b1, 0, 1'b1);
    do_step("t5_clr", 1'b0, 0, 1'b1);

    // Async reset in the middle of a burst.
    do_step("t6_fill", 1'b0, 3, 1'b0);
    do_step("t6_read", 1'b1, 0, 1'b0);
    rst_pulse("t6_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      lvl  = wcnt - rcnt;
      wadd = int'($urandom_range(DEPTH - lvl, 0));
      if (wadd > 2) wadd = 1;
      if ($urandom % 3 == 0) wadd = 0;
      if ($urandom % 100 == 0) rst_pulse("rnd_rst");
      else do_step("rnd", ($urandom % 3) != 0, wadd, ($urandom % 8) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
